// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl
// Ping-pong frame-buffer controller. The camera writes into one half of a
// shared 2*DEPTH pixel BRAM while the VGA path reads the other half. Banks
// swap only at a VGA start of frame, and only once a complete camera frame
// has been written, so the display never shows a torn frame.
//
// Ports
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_cam_done         camera configured; capture disabled while low
//   i_single, i_arm    single-shot mode select and arm pulse
//   i_wr_sof/i_wr_eof  camera frame start/end pulses
//   i_pix_valid        one camera pixel available this cycle
//   o_wr_en/o_wr_addr  BRAM write port (registered)
//   i_rd_sof           VGA start of frame
//   i_rd_pix_addr      VGA pixel index
//   o_rd_addr          BRAM read address (registered, clamped to the bank)
//   o_wr_bank/o_rd_bank current write / display bank (always differ)
//   o_busy             high in ARMED, CAPTURE and HOLD
//
// Optional build macro FRAME_BANK_STATS_EN adds o_frame_cnt (bank swaps)
// and o_drop_cnt (short frames + camera SOF received in HOLD).
//
// state   | meaning
// IDLE    | capture disabled or waiting for an arm pulse
// ARMED   | waiting for camera start of frame
// CAPTURE | writing pixels into the write bank
// HOLD    | full frame written, waiting for VGA start of frame to swap

module frame_bank_ctrl #(
  parameter int DEPTH  = 23680,
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 15
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cam_done,
  input  logic              i_single,
  input  logic              i_arm,
  input  logic              i_wr_sof,
  input  logic              i_wr_eof,
  input  logic              i_pix_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  input  logic              i_rd_sof,
  input  logic [PIX_W-1:0]  i_rd_pix_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_bank,
  output logic              o_rd_bank,
  output logic              o_busy
`ifdef FRAME_BANK_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam logic [PIX_W-1:0]  DEPTH_P = PIX_W'(DEPTH);
  localparam logic [PIX_W-1:0]  LAST_P  = PIX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PIX_W-1:0]    r_cnt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_bank;
  logic                w_accept;
  logic                w_cnt_clr;
  logic                w_swap;
  logic [PIX_W-1:0]    w_rd_pix;
  logic [ADDR_W-1:0]   w_wr_base;
  logic [ADDR_W-1:0]   w_rd_base;

  // Next-state logic. Losing i_cam_done overrides everything.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_cnt_clr = 1'b0;
    w_swap    = 1'b0;
    if (!i_cam_done) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!i_single || i_arm) w_next = S_ARMED;
        end
        S_ARMED: begin
          if (i_wr_sof) begin
            w_next    = S_CAPTURE;
            w_cnt_clr = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (i_wr_sof) begin
            w_cnt_clr = 1'b1;
          end else if (i_wr_eof) begin
            // A short frame is discarded; the bank is reused for the next one.
            w_next = (r_cnt == DEPTH_P) ? S_HOLD : S_ARMED;
          end else if (i_pix_valid && (r_cnt < DEPTH_P)) begin
            w_accept = 1'b1;
          end
        end
        S_HOLD: begin
          if (i_rd_sof) begin
            w_swap = 1'b1;
            w_next = i_single ? S_IDLE : S_ARMED;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  assign w_wr_base = r_wr_bank ? DEPTH_A : '0;
  assign w_rd_base = r_wr_bank ? '0 : DEPTH_A;
  assign w_rd_pix  = (i_rd_pix_addr >= DEPTH_P) ? LAST_P : i_rd_pix_addr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_bank <= 1'b1;
    end else begin
      r_wr_en   <= w_accept;
      r_rd_addr <= w_rd_base + ADDR_W'(w_rd_pix);
      if (w_accept) r_wr_addr <= w_wr_base + ADDR_W'(r_cnt);
      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + PIX_W'(1);
      if (w_swap) r_wr_bank <= ~r_wr_bank;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_rd_addr = r_rd_addr;
  assign o_wr_bank = r_wr_bank;
  // Display bank is derived from the write bank so the two can never collide.
  assign o_rd_bank = ~r_wr_bank;
  assign o_busy    = (r_state != S_IDLE);

`ifdef FRAME_BANK_STATS_EN
  logic        w_short;
  logic        w_hold_sof;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  assign w_short    = i_cam_done && (r_state == S_CAPTURE) && !i_wr_sof &&
                      i_wr_eof && (r_cnt != DEPTH_P);
  assign w_hold_sof = i_cam_done && (r_state == S_HOLD) && i_wr_sof;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_swap) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_short || w_hold_sof) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
`endif

endmodule
